alu_biu: RTL and testbench
==========================

ALU_BIU -- requirements
Module: alu_biu

Interface
REQ-001 Parameters SHALL be none; all widths fixed at 32-bit data/address.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 instr  input  32  current RV32I instruction word.
REQ-005 instr_addr  input  32  address of instr.
REQ-006 r1, r2  input  32 each  source register values.
REQ-007 alu_op  input  5  ALU operation select.
REQ-008 valid  input  1  instruction present this cycle.
REQ-009 ready  output  1  instruction may retire this cycle.
REQ-010 result  output  32  combinational ALU result.
REQ-011 read_result  output  32  registered, extended load data.
REQ-012 misaligned  output  1  combinational, current memory op misaligned.
REQ-013 bus_addr  output  32 and bus_lanes  output  4 and bus_dout  output  32 and bus_wr  output  1 and bus_valid  output  1  registered bus request.
REQ-014 bus_din  input  32 and bus_ready  input  1  bus response.

Function
REQ-015 Immediates SHALL be i_imm = sext(instr[31:20]), s_imm = sext({instr[31:25],instr[11:7]}), u_imm = {instr[31:12],12'h000}.
REQ-016 ALU operand B SHALL be r2 when instr[6:0]=0x33, else i_imm; shift amount = B[4:0].
REQ-017 alu_op SHALL encode: 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 LUI (u_imm), 11 AUIPC (instr_addr+u_imm), 12 LINK (instr_addr+4); all other codes -> 0; all arithmetic modulo 2^32.
REQ-018 Memory op SHALL be load when instr[6:0]=0x03, store when 0x23; effective address = r1+i_imm (load) or r1+s_imm (store).
REQ-019 Size from funct3[1:0]: 0 byte, 1 half, 2 word; funct3[2] on loads = zero-extend (LBU/LHU), else sign-extend.
REQ-020 Misaligned SHALL be half with addr[0]=1 or word with addr[1:0]!=0; misaligned op performs no bus access, ready=1 same cycle, read_result unchanged.
REQ-021 bus_addr SHALL be {addr[31:2],2'b00}; lanes byte=0001<<addr[1:0], half=0011<<addr[1:0], word=1111.
REQ-022 bus_dout SHALL be r2 shifted left by 8*addr[1:0] (byte/half lanes aligned); bus_wr=1 for stores only.
REQ-023 FSM IDLE/BUS: IDLE with valid and aligned mem op -> load request registers, bus_valid=1, go BUS; BUS holds all bus outputs stable until bus_ready=1.
REQ-024 In BUS with bus_ready=1: bus_valid<=0, bus_wr<=0, load data captured (bus_din shifted right by 8*addr[1:0], then extended) into read_result, return IDLE, ready=1 that cycle.
REQ-025 ready SHALL be 1 combinationally when valid is low or instr is not a memory op; 0 in IDLE on issue cycle and in BUS until bus_ready.
REQ-026 Store completion SHALL leave read_result unchanged.
REQ-027 Back-to-back mem ops SHALL issue no earlier than the cycle after completion (one IDLE cycle minimum).

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, bus_valid=0, bus_wr=0, bus_addr=0, bus_lanes=0, bus_dout=0, read_result=0; reset mid-transfer abandons it.

Configuration
REQ-029 Macro ALU_MUL_EN defined SHALL add alu_op 16 MUL (low 32), 17 MULH (s*s), 18 MULHSU (s*u), 19 MULHU (u*u) high 32 bits of 64-bit product, combinational; undefined SHALL return 0 for codes 16-19 and synthesize no multiplier.

Verification
REQ-030 ADDI r1=5, imm=-3, alu_op=0 -> result=2; SRA r1=0x80000000, r2=4, op=0x33, alu_op=7 -> result=0xF8000000.
REQ-031 LB r1=0x1000, imm=3, bus_din=0x80FF_FF_FF after 2 wait cycles -> bus_addr=0x1000, lanes=1000, read_result=0xFFFFFF80, ready only on bus_ready cycle.
REQ-032 SH r1=0x2002, imm=0, r2=0x1234 -> bus_addr=0x2000, lanes=1100, bus_dout=0x12340000, bus_wr=1.
REQ-033 LW r1=0x3001 -> misaligned=1, bus_valid stays 0, ready=1 immediately.
REQ-034 rst_n low while in BUS -> bus_valid=0 immediately, IDLE, read_result=0.
REQ-035 With ALU_MUL_EN: MULHU r1=r2=0xFFFFFFFF -> result=0xFFFFFFFE; without -> 0.

Source files
------------

// File: rtl/alu_biu.sv
// alu_biu: RV32I ALU plus a single-outstanding load/store bus interface unit.
// Latency: ALU result and misaligned are combinational; an aligned memory op issues in one cycle, then retires on the bus_ready cycle.
// Backpressure: ready is held low from issue until bus_ready; all bus outputs are held stable while waiting. Optional macro: ALU_MUL_EN (alu_op 16-19 multiply).
module alu_biu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] instr_addr,
  input  logic [31:0] r1,
  input  logic [31:0] r2,
  input  logic [4:0]  alu_op,
  input  logic        valid,
  output logic        ready,
  output logic [31:0] result,
  output logic [31:0] read_result,
  output logic        misaligned,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_lanes,
  output logic [31:0] bus_dout,
  output logic        bus_wr,
  output logic        bus_valid,
  input  logic [31:0] bus_din,
  input  logic        bus_ready
);

  localparam logic [6:0] OPC_OP    = 7'h33;
  localparam logic [6:0] OPC_LOAD  = 7'h03;
  localparam logic [6:0] OPC_STORE = 7'h23;

  typedef enum logic {ST_IDLE, ST_BUS} state_t;

  state_t      state_q, state_d;
  logic        bus_valid_q, bus_valid_d;
  logic        bus_wr_q, bus_wr_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_lanes_q, bus_lanes_d;
  logic [31:0] bus_dout_q, bus_dout_d;
  logic [31:0] read_result_q, read_result_d;
  // Load formatting info captured at issue so the core may change instr while waiting.
  logic [1:0]  ld_off_q, ld_off_d;
  logic [1:0]  ld_size_q, ld_size_d;
  logic        ld_uns_q, ld_uns_d;

  logic        is_load, is_store, is_mem;
  logic [31:0] i_imm, s_imm, u_imm, op_b, eff_addr;
  logic [4:0]  shamt;
  logic [1:0]  mem_size, mem_off;
  logic        mem_uns;
  logic [3:0]  lanes_c;
  logic [31:0] dout_c, ld_shift, ld_ext;

  assign is_load  = (instr[6:0] == OPC_LOAD);
  assign is_store = (instr[6:0] == OPC_STORE);
  assign is_mem   = is_load | is_store;

  assign i_imm = {{20{instr[31]}}, instr[31:20]};
  assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign u_imm = {instr[31:12], 12'h000};

  assign op_b  = (instr[6:0] == OPC_OP) ? r2 : i_imm;
  assign shamt = op_b[4:0];

  assign eff_addr = r1 + (is_store ? s_imm : i_imm);
  assign mem_size = instr[13:12];
  assign mem_uns  = instr[14];
  assign mem_off  = eff_addr[1:0];

  // Size code 3 is treated as a word access.
  assign misaligned = is_mem & (((mem_size == 2'd1) & mem_off[0]) |
                                (mem_size[1] & (mem_off != 2'b00)));

`ifdef ALU_MUL_EN
  // One shared 64-bit multiplier; operands are sign- or zero-extended per op.
  logic        mul_a_sgn, mul_b_sgn;
  logic [63:0] mul_prod;
  assign mul_a_sgn = (alu_op == 5'd17) || (alu_op == 5'd18);
  assign mul_b_sgn = (alu_op == 5'd17);
  assign mul_prod  = {{32{mul_a_sgn & r1[31]}}, r1} * {{32{mul_b_sgn & op_b[31]}}, op_b};
`endif

  // ALU result selection; unused codes return zero.
  always_comb begin
    result = 32'h0;
    case (alu_op)
      5'd0:  result = r1 + op_b;
      5'd1:  result = r1 - op_b;
      5'd2:  result = r1 << shamt;
      5'd3:  result = {31'b0, $signed(r1) < $signed(op_b)};
      5'd4:  result = {31'b0, r1 < op_b};
      5'd5:  result = r1 ^ op_b;
      5'd6:  result = r1 >> shamt;
      5'd7:  result = $signed(r1) >>> shamt;
      5'd8:  result = r1 | op_b;
      5'd9:  result = r1 & op_b;
      5'd10: result = u_imm;
      5'd11: result = instr_addr + u_imm;
      5'd12: result = instr_addr + 32'd4;
`ifdef ALU_MUL_EN
      5'd16: result = mul_prod[31:0];
      5'd17: result = mul_prod[63:32];
      5'd18: result = mul_prod[63:32];
      5'd19: result = mul_prod[63:32];
`endif
      default: result = 32'h0;
    endcase
  end

  // Store lane enables and lane-aligned write data for the current op.
  always_comb begin
    case (mem_size)
      2'd0:    lanes_c = 4'b0001 << mem_off;
      2'd1:    lanes_c = 4'b0011 << mem_off;
      default: lanes_c = 4'b1111;
    endcase
    dout_c = r2 << {mem_off, 3'b000};
  end

  // Load data alignment and sign/zero extension using the captured op info.
  always_comb begin
    ld_shift = bus_din >> {ld_off_q, 3'b000};
    case (ld_size_q)
      2'd0:    ld_ext = {{24{~ld_uns_q & ld_shift[7]}}, ld_shift[7:0]};
      2'd1:    ld_ext = {{16{~ld_uns_q & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  // Next-state, request register loads and ready handshake.
  always_comb begin
    state_d       = state_q;
    bus_valid_d   = bus_valid_q;
    bus_wr_d      = bus_wr_q;
    bus_addr_d    = bus_addr_q;
    bus_lanes_d   = bus_lanes_q;
    bus_dout_d    = bus_dout_q;
    read_result_d = read_result_q;
    ld_off_d      = ld_off_q;
    ld_size_d     = ld_size_q;
    ld_uns_d      = ld_uns_q;
    ready         = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (valid && is_mem && !misaligned) begin
          ready       = 1'b0;
          state_d     = ST_BUS;
          bus_valid_d = 1'b1;
          bus_wr_d    = is_store;
          bus_addr_d  = {eff_addr[31:2], 2'b00};
          bus_lanes_d = lanes_c;
          bus_dout_d  = dout_c;
          ld_off_d    = mem_off;
          ld_size_d   = mem_size;
          ld_uns_d    = mem_uns;
        end
      end
      ST_BUS: begin
        if (valid && is_mem) ready = bus_ready;
        if (bus_ready) begin
          state_d     = ST_IDLE;
          bus_valid_d = 1'b0;
          bus_wr_d    = 1'b0;
          if (!bus_wr_q) read_result_d = ld_ext;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and bus request registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      bus_valid_q   <= 1'b0;
      bus_wr_q      <= 1'b0;
      bus_addr_q    <= 32'h0;
      bus_lanes_q   <= 4'h0;
      bus_dout_q    <= 32'h0;
      read_result_q <= 32'h0;
      ld_off_q      <= 2'b00;
      ld_size_q     <= 2'b00;
      ld_uns_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      bus_valid_q   <= bus_valid_d;
      bus_wr_q      <= bus_wr_d;
      bus_addr_q    <= bus_addr_d;
      bus_lanes_q   <= bus_lanes_d;
      bus_dout_q    <= bus_dout_d;
      read_result_q <= read_result_d;
      ld_off_q      <= ld_off_d;
      ld_size_q     <= ld_size_d;
      ld_uns_q      <= ld_uns_d;
    end
  end

  assign bus_valid   = bus_valid_q;
  assign bus_wr      = bus_wr_q;
  assign bus_addr    = bus_addr_q;
  assign bus_lanes   = bus_lanes_q;
  assign bus_dout    = bus_dout_q;
  assign read_result = read_result_q;

endmodule

// File: tb/tb_alu_biu.sv
// Testbench for alu_biu: ALU vector table, randomized ALU and memory ops
// against a behavioural model, plus directed load/store/misaligned/reset sequences.
module tb_alu_biu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0, instr_addr = 32'h0, r1 = 32'h0, r2 = 32'h0;
  logic [4:0]  alu_op = 5'd0;
  logic        valid = 1'b0;
  logic        ready;
  logic [31:0] result, read_result;
  logic        misaligned;
  logic [31:0] bus_addr, bus_dout;
  logic [3:0]  bus_lanes;
  logic        bus_wr, bus_valid;
  logic [31:0] bus_din = 32'h0;
  logic        bus_ready = 1'b0;

  int total = 0;
  int bad = 0;
  logic [31:0] rr_model = 32'h0;

  alu_biu dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_addr(instr_addr),
    .r1(r1), .r2(r2), .alu_op(alu_op), .valid(valid), .ready(ready),
    .result(result), .read_result(read_result), .misaligned(misaligned),
    .bus_addr(bus_addr), .bus_lanes(bus_lanes), .bus_dout(bus_dout),
    .bus_wr(bus_wr), .bus_valid(bus_valid), .bus_din(bus_din), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sx12(input logic [11:0] v);
    logic [31:0] x;
    x = {20'h0, v};
    if (x >= 32'd2048) x = x - 32'd4096;
    return x;
  endfunction

  function automatic logic [31:0] mk_i(input logic [11:0] imm, input logic [2:0] f3, input logic [6:0] opc);
    return {imm, 5'd1, f3, 5'd2, opc};
  endfunction

  function automatic logic [31:0] mk_s(input logic [11:0] imm, input logic [2:0] f3);
    return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'h33};
  endfunction

  // Reference ALU computed straight from the operation definitions.
  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] ins, pc, a, rb);
    logic [31:0] b, u;
    int sh;
    longint sa, sb;
    logic [63:0] pu;
    b  = (ins[6:0] == 7'h33) ? rb : sx12(ins[31:20]);
    sh = int'(b % 32);
    u  = ins & 32'hFFFFF000;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    pu = {32'h0, a} * {32'h0, b};
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << sh;
      5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  return (a < b) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return a >> sh;
      5'd7:  return a[31] ? ~((~a) >> sh) : (a >> sh);
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: return u;
      5'd11: return pc + u;
      5'd12: return pc + 32'd4;
`ifdef ALU_MUL_EN
      5'd16: return pu[31:0];
      5'd17: begin pu = 64'(sa * sb); return pu[63:32]; end
      5'd18: begin pu = 64'(sa * longint'({32'h0, b})); return pu[63:32]; end
      5'd19: return pu[63:32];
`endif
      default: return 32'h0;
    endcase
  endfunction

  // One memory op from IDLE (called #1 after a rising edge); checks request, wait hold, completion.
  task automatic mem_op(input string nm, input logic [31:0] ins, a, b, input int waits, input logic [31:0] din);
    logic        st, mis;
    logic [2:0]  f3;
    logic [31:0] addr, imm, v, mask, exp_rr;
    int          nb, off;
    logic [3:0]  lanes;
    st   = (ins[6:0] == 7'h23);
    imm  = st ? sx12({ins[31:25], ins[11:7]}) : sx12(ins[31:20]);
    addr = a + imm;
    f3   = ins[14:12];
    nb   = 1 << f3[1:0];
    off  = int'(addr % 4);
    mis  = (addr % nb) != 0;
    lanes = 4'(((1 << nb) - 1) << off);
    mask = (nb == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * nb)) - 32'd1);
    v    = (din >> (8 * off)) & mask;
    if (!f3[2] && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
    exp_rr = st ? rr_model : v;

    instr = ins; r1 = a; r2 = b; alu_op = 5'd0; valid = 1'b1; bus_ready = 1'b0;
    #1;
    chk({nm, " misaligned"}, {31'b0, misaligned}, {31'b0, mis});
    if (mis) begin
      chk({nm, " ready_mis"}, {31'b0, ready}, 32'd1);
      @(posedge clk); #1;
      chk({nm, " no_bus_mis"}, {31'b0, bus_valid}, 32'd0);
      chk({nm, " rr_mis"}, read_result, rr_model);
      valid = 1'b0;
    end else begin
      chk({nm, " ready_issue"}, {31'b0, ready}, 32'd0);
      @(posedge clk); #1;
      chk({nm, " bus_valid"}, {31'b0, bus_valid}, 32'd1);
      chk({nm, " bus_wr"}, {31'b0, bus_wr}, {31'b0, st});
      chk({nm, " bus_addr"}, bus_addr, addr & 32'hFFFFFFFC);
      chk({nm, " bus_lanes"}, {28'b0, bus_lanes}, {28'b0, lanes});
      chk({nm, " bus_dout"}, bus_dout, b << (8 * off));
      for (int w = 0; w < waits; w++) begin
        chk({nm, " ready_wait"}, {31'b0, ready}, 32'd0);
        @(posedge clk); #1;
        chk({nm, " hold_valid"}, {31'b0, bus_valid}, 32'd1);
        chk({nm, " hold_addr"}, bus_addr, addr & 32'hFFFFFFFC);
      end
      bus_ready = 1'b1; bus_din = din;
      #1;
      chk({nm, " ready_done"}, {31'b0, ready}, 32'd1);
      @(posedge clk); #1;
      valid = 1'b0; bus_ready = 1'b0;
      chk({nm, " valid_clear"}, {31'b0, bus_valid}, 32'd0);
      chk({nm, " wr_clear"}, {31'b0, bus_wr}, 32'd0);
      chk({nm, " read_result"}, read_result, exp_rr);
      rr_model = exp_rr;
    end
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs[15];
  logic [6:0] opcs[5];

  initial begin
    vecs[0]  = '{mk_i(12'hFFD, 3'd0, 7'h13), 32'h0, 32'd5, 32'h0, 5'd0, 32'd2};
    vecs[1]  = '{mk_r(7'h20, 3'd5), 32'h0, 32'h80000000, 32'd4, 5'd7, 32'hF8000000};
    vecs[2]  = '{mk_r(7'h20, 3'd0), 32'h0, 32'd3, 32'd5, 5'd1, 32'hFFFFFFFE};
    vecs[3]  = '{mk_r(7'h00, 3'd2), 32'h0, 32'hFFFFFFFF, 32'd1, 5'd3, 32'd1};
    vecs[4]  = '{mk_r(7'h00, 3'd3), 32'h0, 32'hFFFFFFFF, 32'd1, 5'd4, 32'd0};
    vecs[5]  = '{mk_r(7'h00, 3'd1), 32'h0, 32'd1, 32'h21, 5'd2, 32'd2};
    vecs[6]  = '{{20'hABCDE, 5'd3, 7'h37}, 32'h0, 32'h0, 32'h0, 5'd10, 32'hABCDE000};
    vecs[7]  = '{{20'h00001, 5'd3, 7'h17}, 32'h100, 32'h0, 32'h0, 5'd11, 32'h1100};
    vecs[8]  = '{{20'h00000, 5'd1, 7'h6F}, 32'hFFFFFFFC, 32'h0, 32'h0, 5'd12, 32'h0};
    vecs[9]  = '{mk_i(12'h001, 3'd0, 7'h13), 32'h0, 32'd5, 32'h0, 5'd13, 32'h0};
`ifdef ALU_MUL_EN
    vecs[10] = '{mk_r(7'h01, 3'd3), 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd19, 32'hFFFFFFFE};
`else
    vecs[10] = '{mk_r(7'h01, 3'd3), 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd19, 32'h0};
`endif
    vecs[11] = '{mk_i(12'h800, 3'd4, 7'h13), 32'h0, 32'h0000FFFF, 32'h0, 5'd5, 32'hFFFF07FF};
    vecs[12] = '{mk_r(7'h00, 3'd5), 32'h0, 32'h80000000, 32'd31, 5'd6, 32'd1};
    vecs[13] = '{mk_i(12'h0FF, 3'd7, 7'h13), 32'h0, 32'h0000F0F0, 32'h0, 5'd9, 32'h000000F0};
    vecs[14] = '{mk_r(7'h00, 3'd6), 32'h0, 32'h1, 32'h10, 5'd8, 32'h11};
    opcs = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6F};

    // Reset state
    #2;
    chk("rst bus_valid", {31'b0, bus_valid}, 32'd0);
    chk("rst bus_wr", {31'b0, bus_wr}, 32'd0);
    chk("rst bus_addr", bus_addr, 32'h0);
    chk("rst bus_lanes", {28'b0, bus_lanes}, 32'h0);
    chk("rst bus_dout", bus_dout, 32'h0);
    chk("rst read_result", read_result, 32'h0);
    #10 rst_n = 1'b1;

    // ALU vector table
    valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      instr = vecs[i].ins; instr_addr = vecs[i].pc; r1 = vecs[i].a; r2 = vecs[i].b; alu_op = vecs[i].op;
      #1;
      chk($sformatf("alu_vec[%0d] result", i), result, vecs[i].exp);
      chk($sformatf("alu_vec[%0d] ready", i), {31'b0, ready}, 32'd1);
    end

    // Randomized ALU against the reference model
    for (int i = 0; i < 200; i++) begin
      logic [31:0] t;
      t = $urandom();
      instr = {t[31:7], opcs[$urandom_range(0, 4)]};
      instr_addr = $urandom(); r1 = $urandom(); r2 = $urandom();
      if (i % 4 == 0) r2 = 32'($urandom_range(0, 40));
      alu_op = 5'($urandom_range(0, 20));
      #1;
      chk($sformatf("alu_rand[%0d] op%0d", i, alu_op), result, ref_alu(alu_op, instr, instr_addr, r1, r2));
    end

    // Memory instruction without valid retires immediately and issues nothing
    valid = 1'b0;
    instr = mk_i(12'h0, 3'd2, 7'h03); r1 = 32'h100;
    @(posedge clk); #1;
    chk("idle ready", {31'b0, ready}, 32'd1);
    @(posedge clk); #1;
    chk("idle no_bus", {31'b0, bus_valid}, 32'd0);

    // Directed load/store/misaligned cases
    mem_op("LB", mk_i(12'd3, 3'd0, 7'h03), 32'h1000, 32'h0, 2, 32'h80FFFFFF);
    chk("LB value", read_result, 32'hFFFFFF80);
    mem_op("SH", mk_s(12'd0, 3'd1), 32'h2002, 32'h1234, 0, 32'hDEADBEEF);
    chk("SH keeps rr", read_result, 32'hFFFFFF80);
    mem_op("LW_mis", mk_i(12'd0, 3'd2, 7'h03), 32'h3001, 32'h0, 0, 32'h0);
    mem_op("LHU", mk_i(12'd2, 3'd5, 7'h03), 32'h4000, 32'h0, 1, 32'h8001_7777);
    mem_op("LW_b2b", mk_i(12'd4, 3'd2, 7'h03), 32'h4000, 32'h0, 0, 32'hCAFEF00D);

    // Randomized memory ops, back to back
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  f3;
      logic [11:0] imm;
      logic [31:0] a, ins;
      imm = 12'($urandom_range(0, 4095));
      a = $urandom();
      if ($urandom_range(0, 1) == 1) begin
        f3 = 3'($urandom_range(0, 2));
        ins = mk_s(imm, f3);
      end else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
        ins = mk_i(imm, f3, 7'h03);
      end
      mem_op($sformatf("mem_rand[%0d]", i), ins, a, $urandom(), $urandom_range(0, 3), $urandom());
    end

    // Reset while a transfer is outstanding
    instr = mk_i(12'd0, 3'd2, 7'h03); r1 = 32'h5000; valid = 1'b1;
    @(posedge clk); #1;
    chk("rstmid bus_valid_before", {31'b0, bus_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid bus_valid", {31'b0, bus_valid}, 32'd0);
    chk("rstmid bus_addr", bus_addr, 32'h0);
    chk("rstmid read_result", read_result, 32'h0);
    bus_ready = 1'b1;
    #1;
    chk("rstmid idle_ready", {31'b0, ready}, 32'd0);
    valid = 1'b0; bus_ready = 1'b0;
    #2 rst_n = 1'b1;
    rr_model = 32'h0;
    @(posedge clk); #1;
    chk("rstmid stays idle", {31'b0, bus_valid}, 32'd0);
    mem_op("LB_after_rst", mk_i(12'd1, 3'd4, 7'h03), 32'h6000, 32'h0, 1, 32'h0000A500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
